// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage pipelined single-precision comparator that returns
// RISC-V F ordering and equality results (FEQ, FLT, FLE) as a 32-bit integer.
// The operation tag travels with each operation. Results leave in acceptance order.
//
// Stage 1 registers only a compact classification of the operand pair.
// Stage 2 resolves that classification into the result and registers it.
// The input is stalled by a purely combinational backward-ready chain, and
// there is no skid buffer.
//
// Optional build macro:
//   FCMP_FFLAGS_EN - adds the registered fflags[4:0] output. Only the NV bit
//                    (bit 4) is ever set. Without the macro, the block builds
//                    no quiet/signaling NaN distinction.

module fcmp_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag
`ifdef FCMP_FFLAGS_EN
    ,
    output logic [4:0]       fflags
`endif
);

    localparam logic [1:0] OP_FEQ = 2'b00;
    localparam logic [1:0] OP_FLT = 2'b01;
    localparam logic [1:0] OP_FLE = 2'b10;

    // ------------------------------------------------------------------
    // Handshake / stall chain
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ------------------------------------------------------------------
    // Operand classification (input side of stage 1)
    // ------------------------------------------------------------------
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [22:0] m1;
    logic [22:0] m2;
    logic        c_nan1;
    logic        c_nan2;
    logic        c_zero1;
    logic        c_zero2;
    logic        c_eq_bits;
    logic        c_mag_lt;
    logic        c_mag_eq;

    assign e1 = x1[30:23];
    assign e2 = x2[30:23];
    assign m1 = x1[22:0];
    assign m2 = x2[22:0];

    // The magnitude compare spans exponent and mantissa together. This
    // orders infinities and subnormals correctly without special handling.
    assign c_nan1    = (e1 == 8'hff) && (m1 != 23'd0);
    assign c_nan2    = (e2 == 8'hff) && (m2 != 23'd0);
    assign c_zero1   = (e1 == 8'h00) && (m1 == 23'd0);
    assign c_zero2   = (e2 == 8'h00) && (m2 == 23'd0);
    assign c_eq_bits = (x1 == x2);
    assign c_mag_lt  = (x1[30:0] < x2[30:0]);
    assign c_mag_eq  = (x1[30:0] == x2[30:0]);

`ifdef FCMP_FFLAGS_EN
    logic c_snan1;
    logic c_snan2;

    // A signaling NaN has the quiet bit (mantissa MSB) clear.
    assign c_snan1 = c_nan1 && !m1[22];
    assign c_snan2 = c_nan2 && !m2[22];
`endif

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic             s1_nan1;
    logic             s1_nan2;
    logic             s1_zero1;
    logic             s1_zero2;
    logic             s1_sgn1;
    logic             s1_sgn2;
    logic             s1_eq_bits;
    logic             s1_mag_lt;
    logic             s1_mag_eq;
    logic [1:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
`ifdef FCMP_FFLAGS_EN
    logic             s1_snan1;
    logic             s1_snan2;
`endif

    // Stage 1: capture the classification of an accepted pair. The valid
    // bit follows in_valid whenever the stage is allowed to advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_nan1    <= 1'b0;
            s1_nan2    <= 1'b0;
            s1_zero1   <= 1'b0;
            s1_zero2   <= 1'b0;
            s1_sgn1    <= 1'b0;
            s1_sgn2    <= 1'b0;
            s1_eq_bits <= 1'b0;
            s1_mag_lt  <= 1'b0;
            s1_mag_eq  <= 1'b0;
            s1_op      <= 2'b00;
            s1_tag     <= '0;
`ifdef FCMP_FFLAGS_EN
            s1_snan1   <= 1'b0;
            s1_snan2   <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_nan1    <= c_nan1;
                s1_nan2    <= c_nan2;
                s1_zero1   <= c_zero1;
                s1_zero2   <= c_zero2;
                s1_sgn1    <= x1[31];
                s1_sgn2    <= x2[31];
                s1_eq_bits <= c_eq_bits;
                s1_mag_lt  <= c_mag_lt;
                s1_mag_eq  <= c_mag_eq;
                s1_op      <= op;
                s1_tag     <= in_tag;
`ifdef FCMP_FFLAGS_EN
                s1_snan1   <= c_snan1;
                s1_snan2   <= c_snan2;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Result resolution (input side of stage 2)
    // ------------------------------------------------------------------
    logic both_zero;
    logic any_nan;
    logic r_feq;
    logic r_flt;
    logic r_fle;
    logic r_res;

    // Resolve FEQ, FLT and FLE from the stage-1 fields. A NaN operand forces
    // the result to 0 for every operation, and the reserved op also gives 0.
    always_comb begin
        both_zero = s1_zero1 && s1_zero2;
        any_nan   = s1_nan1 || s1_nan2;

        // +0 and -0 compare equal even though their bit patterns differ.
        r_feq = both_zero || s1_eq_bits;

        if (both_zero) begin
            r_flt = 1'b0;
        end else if (s1_sgn1 != s1_sgn2) begin
            r_flt = s1_sgn1;
        end else if (!s1_sgn1) begin
            r_flt = s1_mag_lt;
        end else begin
            r_flt = !s1_mag_lt && !s1_mag_eq;
        end

        r_fle = r_flt || r_feq;

        case (s1_op)
            OP_FEQ:  r_res = r_feq;
            OP_FLT:  r_res = r_flt;
            OP_FLE:  r_res = r_fle;
            default: r_res = 1'b0;
        endcase

        if (any_nan) begin
            r_res = 1'b0;
        end
    end

`ifdef FCMP_FFLAGS_EN
    logic r_nv;

    // FEQ raises the invalid flag only for signaling NaNs. The ordered
    // compares raise it for any NaN.
    always_comb begin
        case (s1_op)
            OP_FEQ:         r_nv = s1_snan1 || s1_snan2;
            OP_FLT, OP_FLE: r_nv = s1_nan1 || s1_nan2;
            default:        r_nv = 1'b0;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Stage 2 registers (block outputs)
    // ------------------------------------------------------------------

    // Stage 2: the output registers. They hold their value while the
    // consumer stalls. They load only when a real entry moves in, so a
    // bubble leaves the last value in place (out_valid is low during it).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= 32'd0;
            out_tag   <= '0;
`ifdef FCMP_FFLAGS_EN
            fflags    <= 5'd0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y       <= {31'd0, r_res};
                out_tag <= s1_tag;
`ifdef FCMP_FFLAGS_EN
                fflags  <= {r_nv, 4'b0000};
`endif
            end
        end
    end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe. It checks directed table vectors, the
// backpressure and reset sequences, and randomized traffic against a
// value-level reference model.
// Build with FCMP_FFLAGS_EN defined to also check the fflags output.

module tb_fcmp_pipe;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      y;
    logic [TAG_W-1:0] out_tag;
`ifdef FCMP_FFLAGS_EN
    logic [4:0]       fflags;
`endif

    fcmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x1        (x1),
        .x2        (x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_tag   (out_tag)
`ifdef FCMP_FFLAGS_EN
        ,
        .fflags    (fflags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model. It orders floats by numeric value: sign-magnitude
    // is mapped onto a signed integer, so +0 and -0 both map to 0.
    // ------------------------------------------------------------------
    typedef struct {
        logic             r;
        logic             nv;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    endfunction

    function automatic int fkey(input logic [31:0] a);
        int m;
        m = int'({1'b0, a[30:0]});
        return a[31] ? -m : m;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic [TAG_W-1:0] t);
        exp_t e;
        logic anyn;
        logic snan;
        anyn  = is_nan(a) || is_nan(b);
        snan  = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
        e.tag = t;
        e.r   = 1'b0;
        e.nv  = 1'b0;
        case (o)
            2'd0: begin e.r = !anyn && (fkey(a) == fkey(b)); e.nv = snan; end
            2'd1: begin e.r = !anyn && (fkey(a) <  fkey(b)); e.nv = anyn; end
            2'd2: begin e.r = !anyn && (fkey(a) <= fkey(b)); e.nv = anyn; end
            default: ;
        endcase
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: scoreboard and stall-stability checks on the falling edge
    // ------------------------------------------------------------------
    initial begin
        logic             hold_chk;
        logic [31:0]      hold_y;
        logic [TAG_W-1:0] hold_tag;
        exp_t             e;
        hold_chk = 1'b0;
        hold_y   = '0;
        hold_tag = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_y", y, hold_y);
                    chk("stall_tag", 32'(out_tag), 32'(hold_tag));
                end
                hold_chk = out_valid && !out_ready;
                hold_y   = y;
                hold_tag = out_tag;
                if (out_valid && out_ready) begin
                    chk("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("sb_y", y, {31'd0, e.r});
                        chk("sb_tag", 32'(out_tag), 32'(e.tag));
`ifdef FCMP_FFLAGS_EN
                        chk("sb_fflags", 32'(fflags), 32'({e.nv, 4'b0000}));
`endif
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(op, x1, x2, in_tag));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
        op     = o;
        x1     = a;
        x2     = b;
        in_tag = t;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!out_valid && exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Sends one operation into an empty pipe and checks its latency, in
    // cycles from the accept cycle, plus its result, tag and flags.
    task automatic run_one(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] t,
                           input logic er, input logic env);
        logic acc;
        int   lat;
        drain();
        drive(o, a, b, t);
        in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        tick();
        in_valid = 1'b0;
        chk({name, "_accept"}, 32'(acc), 32'd1);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            tick();
        end
        chk({name, "_latency"}, 32'(lat), 32'd2);
        chk({name, "_y"}, y, {31'd0, er});
        chk({name, "_tag"}, 32'(out_tag), 32'(t));
`ifdef FCMP_FFLAGS_EN
        chk({name, "_fflags"}, 32'(fflags), 32'({env, 4'b0000}));
`else
        if (env) begin end
`endif
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [12];
        sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
               32'h7FC00000, 32'h7F800001, 32'hFFC00000, 32'h00000001,
               32'h80000001, 32'h3F800000, 32'hBF800000, 32'hC0000000};
        if ($urandom_range(0, 2) == 0) return $urandom;
        return sp[$urandom_range(0, 11)];
    endfunction

    function automatic logic [31:0] pick2(input logic [31:0] a);
        case ($urandom_range(0, 4))
            0: return a;
            1: return a ^ 32'h80000000;
            2: return a + 32'd1;
            default: return pick();
        endcase
    endfunction

    typedef struct {
        string       name;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic        er;
        logic        env;
    } vec_t;

    vec_t vecs[$];

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int   i;
        int   got;
        logic fell;
        logic acc;
        logic seen;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(2'd0, 32'd0, 32'd0, '0);

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
`ifdef FCMP_FFLAGS_EN
        chk("rst_fflags", 32'(fflags), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed table
        vecs.push_back('{"feq_one",      2'd0, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0});
        vecs.push_back('{"feq_zeros",    2'd0, 32'h80000000, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"flt_zeros",    2'd1, 32'h80000000, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"fle_zeros",    2'd2, 32'h80000000, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"flt_neg",      2'd1, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0});
        vecs.push_back('{"flt_sign",     2'd1, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0});
        vecs.push_back('{"fle_inf",      2'd2, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0});
        vecs.push_back('{"flt_qnan",     2'd1, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1});
        vecs.push_back('{"feq_qnan",     2'd0, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0});
        vecs.push_back('{"feq_snan",     2'd0, 32'h7F800001, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{"op_reserved",  2'd3, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0});
        vecs.push_back('{"fle_mixed",    2'd2, 32'hBF800000, 32'h3F800000, 1'b1, 1'b0});
        vecs.push_back('{"flt_denorm_a", 2'd1, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"flt_denorm_b", 2'd1, 32'h00000000, 32'h00000001, 1'b1, 1'b0});
        vecs.push_back('{"fle_qnan",     2'd2, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b1});
        vecs.push_back('{"flt_neginf",   2'd1, 32'hFF800000, 32'hC0000000, 1'b1, 1'b0});
        foreach (vecs[k])
            run_one(vecs[k].name, vecs[k].o, vecs[k].a, vecs[k].b, TAG_W'(k + 3),
                    vecs[k].er, vecs[k].env);

        // Backpressure: 6 back-to-back ops, consumer stalled for 4 cycles
        drain();
        i    = 0;
        got  = 0;
        fell = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'd1, 32'h3F800000 + (32'(i) << 20), 32'h3FA00000, TAG_W'(i));
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!fell && !in_ready) begin
                fell = 1'b1;
                chk("bp_accepts_before_stall", 32'(i), 32'd2);
            end
            if (out_valid && out_ready) begin
                chk("bp_order_tag", 32'(out_tag), 32'(got));
                got++;
            end
            tick();
            if (acc) i++;
            in_valid = (i < 6);
            drive(2'd1, 32'h3F800000 + (32'(i) << 20), 32'h3FA00000, TAG_W'(i));
            out_ready = (c >= 3);
        end
        in_valid = 1'b0;
        chk("bp_stall_seen", 32'(fell), 32'd1);
        chk("bp_result_count", 32'(got), 32'd6);
        chk("bp_accept_count", 32'(i), 32'd6);

        // Reset with two ops in flight
        drain();
        in_valid = 1'b1;
        drive(2'd0, 32'h3F800000, 32'h3F800000, TAG_W'(7));
        tick();
        drive(2'd2, 32'h00000000, 32'h3F800000, TAG_W'(8));
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_y", y, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("arst_no_stale", 32'(seen), 32'd0);
        run_one("post_rst", 2'd0, 32'h40000000, 32'h40000000, TAG_W'(9), 1'b1, 1'b0);

        // Randomized traffic with random backpressure
        drain();
        for (int c = 0; c < 600; c++) begin
            logic [31:0] a;
            a         = pick();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive(2'($urandom_range(0, 3)), a, pick2(a), TAG_W'($urandom));
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
